// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Latches decode control, operands and register addresses for EX. When the
// instruction in EX is a load whose destination is read by the instruction
// in ID, a bubble is loaded into EX and PC/IF-ID are held for one cycle.
// Branch flushes take priority over stalls. Two saturating counters record
// stall and flush cycles for performance reporting.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic              id_regwrite_i,
  input  logic              id_memtoreg_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic [1:0]        id_aluop_i,
  input  logic              id_alusrc_i,
  input  logic              id_branch_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic [9:0]        id_funct_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  output logic              ex_valid_o,
  output logic              ex_regwrite_o,
  output logic              ex_memtoreg_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_alusrc_o,
  output logic              ex_branch_o,
  output logic [DATA_W-1:0] ex_rs1_data_o,
  output logic [DATA_W-1:0] ex_rs2_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc_o,
  output logic [9:0]        ex_funct_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              stall_o,
  output logic              noop_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              valid_q, valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              memread_q, memread_d;
  logic              memwrite_q, memwrite_d;
  logic [1:0]        aluop_q, aluop_d;
  logic              alusrc_q, alusrc_d;
  logic              branch_q, branch_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [9:0]        funct_q, funct_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic stall;
  logic capture;

  // Load-use detection from the registered EX load and the ID source addresses;
  // x0 is never a real dependency. A flush suppresses the stall.
  always_comb begin
    hazard  = valid_q & memread_q & (rd_q != '0) &
              ((rd_q == id_rs1_i) | (rd_q == id_rs2_i)) & id_valid_i;
    stall   = hazard & ~flush_i;
    capture = ~flush_i & ~hazard & id_valid_i;
  end

  // Next EX contents: the ID instruction when captured, otherwise an all-zero
  // bubble so that no unknown control or data value ever reaches EX.
  always_comb begin
    valid_d    = 1'b0;
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    aluop_d    = 2'b00;
    alusrc_d   = 1'b0;
    branch_d   = 1'b0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    pc_d       = '0;
    funct_d    = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    if (capture) begin
      valid_d    = 1'b1;
      regwrite_d = id_regwrite_i;
      memtoreg_d = id_memtoreg_i;
      memread_d  = id_memread_i;
      memwrite_d = id_memwrite_i;
      aluop_d    = id_aluop_i;
      alusrc_d   = id_alusrc_i;
      branch_d   = id_branch_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      imm_d      = id_imm_i;
      pc_d       = id_pc_i;
      funct_d    = id_funct_i;
      rs1_d      = id_rs1_i;
      rs2_d      = id_rs2_i;
      rd_d       = id_rd_i;
    end
  end

  // Saturating performance counters: count while the event holds, stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Pipeline register and counters; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      aluop_q     <= 2'b00;
      alusrc_q    <= 1'b0;
      branch_q    <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      funct_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      aluop_q     <= aluop_d;
      alusrc_q    <= alusrc_d;
      branch_q    <= branch_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      funct_q     <= funct_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_regwrite_o = regwrite_q;
  assign ex_memtoreg_o = memtoreg_q;
  assign ex_memread_o  = memread_q;
  assign ex_memwrite_o = memwrite_q;
  assign ex_aluop_o    = aluop_q;
  assign ex_alusrc_o   = alusrc_q;
  assign ex_branch_o   = branch_q;
  assign ex_rs1_data_o = rs1_data_q;
  assign ex_rs2_data_o = rs2_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_pc_o       = pc_q;
  assign ex_funct_o    = funct_q;
  assign ex_rs1_o      = rs1_q;
  assign ex_rs2_o      = rs2_q;
  assign ex_rd_o       = rd_q;
  assign stall_o       = stall;
  assign noop_o        = stall;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule
